// File: rtl/arbitro_dados.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | arbitro_dados: round-robin arbiter sharing one single-port data memory.  |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module arbitro_dados #(
    parameter int LARGURA_DADO = 8,
    parameter int LARGURA_END  = 8,
    parameter int PROFUNDIDADE = 30
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req0,
    input  logic                    req1,
    input  logic                    esc0,
    input  logic                    esc1,
    input  logic [LARGURA_END-1:0]  end0,
    input  logic [LARGURA_END-1:0]  end1,
    input  logic [LARGURA_DADO-1:0] dado0,
    input  logic [LARGURA_DADO-1:0] dado1,
    output logic                    ack0,
    output logic                    ack1,
    output logic [LARGURA_DADO-1:0] dado_lido,
    output logic                    erro,
    output logic [LARGURA_END-1:0]  label,
    output logic [LARGURA_DADO-1:0] dadoEscrito,
    output logic                    LerMemo,
    output logic                    EscrMemo,
    input  logic [LARGURA_DADO-1:0] escrever
);

    typedef enum logic [1:0] {
        OCIOSO   = 2'd0,
        ESCRITA  = 2'd1,
        LEITURA  = 2'd2,
        RESPOSTA = 2'd3
    } estado_t;

    localparam logic [LARGURA_END:0] LIMITE = (LARGURA_END+1)'(PROFUNDIDADE);

    estado_t estado_q;
    logic    sel_q;
    logic    ultimo_q;
    logic    dentro_q;

    logic                    sel_d;
    logic                    esc_d;
    logic [LARGURA_END-1:0]  end_d;
    logic [LARGURA_DADO-1:0] dado_d;
    logic                    dentro_d;

    // Requester 1 wins when alone, or on contention when 0 was served last.
    always_comb begin
        sel_d    = req1 && (!req0 || !ultimo_q);
        esc_d    = sel_d ? esc1  : esc0;
        end_d    = sel_d ? end1  : end0;
        dado_d   = sel_d ? dado1 : dado0;
        dentro_d = ({1'b0, end_d} < LIMITE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            estado_q    <= OCIOSO;
            sel_q       <= 1'b0;
            ultimo_q    <= 1'b1;
            dentro_q    <= 1'b0;
            ack0        <= 1'b0;
            ack1        <= 1'b0;
            erro        <= 1'b0;
            dado_lido   <= '0;
            LerMemo     <= 1'b0;
            EscrMemo    <= 1'b0;
            label       <= '0;
            dadoEscrito <= '0;
        end else begin
            case (estado_q)
                OCIOSO: begin
                    ack0 <= 1'b0;
                    ack1 <= 1'b0;
                    if (req0 || req1) begin
                        sel_q       <= sel_d;
                        ultimo_q    <= sel_d;
                        dentro_q    <= dentro_d;
                        label       <= end_d;
                        dadoEscrito <= dado_d;
                        // Strobes are registered here so they are high exactly in the access cycle.
                        if (esc_d) begin
                            estado_q <= ESCRITA;
                            EscrMemo <= dentro_d;
                        end else begin
                            estado_q <= LEITURA;
                            LerMemo  <= dentro_d;
                        end
                    end
                end
                ESCRITA: begin
                    EscrMemo  <= 1'b0;
                    dado_lido <= '0;
                    erro      <= !dentro_q;
                    ack0      <= !sel_q;
                    ack1      <= sel_q;
                    estado_q  <= RESPOSTA;
                end
                LEITURA: begin
                    LerMemo   <= 1'b0;
                    dado_lido <= dentro_q ? escrever : '0;
                    erro      <= !dentro_q;
                    ack0      <= !sel_q;
                    ack1      <= sel_q;
                    estado_q  <= RESPOSTA;
                end
                RESPOSTA: begin
                    ack0     <= 1'b0;
                    ack1     <= 1'b0;
                    estado_q <= OCIOSO;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_arbitro_dados.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_arbitro_dados: directed + random bench with a transaction-level model. |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_arbitro_dados;

    localparam int PROF = 30;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       req0 = 1'b0, req1 = 1'b0, esc0 = 1'b0, esc1 = 1'b0;
    logic [7:0] end0 = '0, end1 = '0, dado0 = '0, dado1 = '0;
    logic       ack0, ack1, erro, LerMemo, EscrMemo;
    logic [7:0] dado_lido, label, dadoEscrito;
    logic [7:0] escrever = '0;

    always #5 clk = ~clk;

    arbitro_dados #(.LARGURA_DADO(8), .LARGURA_END(8), .PROFUNDIDADE(PROF)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .esc0(esc0), .esc1(esc1),
        .end0(end0), .end1(end1), .dado0(dado0), .dado1(dado1),
        .ack0(ack0), .ack1(ack1), .dado_lido(dado_lido), .erro(erro),
        .label(label), .dadoEscrito(dadoEscrito),
        .LerMemo(LerMemo), .EscrMemo(EscrMemo), .escrever(escrever)
    );

    // Memory environment: read data appears at negedge, writes land at posedge.
    logic [7:0] mem [0:PROF-1];
    always @(negedge clk)
        if (LerMemo) escrever <= (label < PROF) ? mem[label] : 8'hEE;
    always @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < PROF; i++) mem[i] <= '0;
        end else if (EscrMemo && label < PROF) begin
            mem[label] <= dadoEscrito;
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Transaction-level reference: each granted access takes an access cycle then an ack cycle.
    int         fase = 0;
    bit         ultimo = 1'b1;
    bit         m_sel, m_esc, m_ok;
    logic [7:0] m_addr, m_data;
    logic [7:0] ref_mem [0:255];
    logic [1:0] e_ack = '0, e_strb = '0;
    logic       e_erro = 1'b0;
    logic [7:0] e_dado = '0, e_label = '0, e_dw = '0;

    task automatic model_edge();
        if (!reset) begin
            fase = 0; ultimo = 1'b1;
            e_ack = '0; e_strb = '0; e_erro = 1'b0;
            e_dado = '0; e_label = '0; e_dw = '0;
            for (int i = 0; i < 256; i++) ref_mem[i] = '0;
        end else if (fase == 0) begin
            e_ack = '0;
            if (req0 || req1) begin
                m_sel  = (req0 && req1) ? !ultimo : req1;
                ultimo = m_sel;
                m_esc  = m_sel ? esc1 : esc0;
                m_addr = m_sel ? end1 : end0;
                m_data = m_sel ? dado1 : dado0;
                m_ok   = (m_addr < PROF);
                e_label = m_addr;
                e_dw    = m_data;
                e_strb  = !m_ok ? 2'b00 : (m_esc ? 2'b10 : 2'b01);
                fase = 1;
            end
        end else if (fase == 1) begin
            e_strb = '0;
            e_ack  = m_sel ? 2'b10 : 2'b01;
            e_erro = !m_ok;
            e_dado = (!m_esc && m_ok) ? ref_mem[m_addr] : 8'h00;
            if (m_esc && m_ok) ref_mem[m_addr] = m_data;
            fase = 2;
        end else begin
            e_ack = '0;
            fase  = 0;
        end
    endtask

    task automatic step();
        bit was_reset;
        was_reset = !reset;
        model_edge();
        @(posedge clk); #1;
        chk("ack", {ack1, ack0}, e_ack);
        chk("strobe", {EscrMemo, LerMemo}, e_strb);
        if (was_reset) begin
            chk("rst_erro", erro, 0);
            chk("rst_dado_lido", dado_lido, 0);
            chk("rst_label", label, 0);
            chk("rst_dadoEscrito", dadoEscrito, 0);
        end else if (fase == 1) begin
            chk("label", label, e_label);
            if (m_esc) chk("wdata", dadoEscrito, e_dw);
        end else if (fase == 2) begin
            chk("erro", erro, e_erro);
            chk("rdata", dado_lido, e_dado);
        end
    endtask

    task automatic drive(input int r, input bit on, input bit esc, input logic [7:0] a,
                         input logic [7:0] d);
        if (r == 0) begin req0 = on; esc0 = esc; end0 = a; dado0 = d; end
        else        begin req1 = on; esc1 = esc; end1 = a; dado1 = d; end
    endtask

    // Issue one request, wait (bounded) for its ack, then drop req on the ack edge.
    task automatic run_txn(input int r, input bit esc, input logic [7:0] a, input logic [7:0] d,
                           output logic [7:0] rd, output logic er, output int lat);
        drive(r, 1'b1, esc, a, d);
        lat = 0;
        do begin
            step();
            lat++;
        end while (!((r == 1) ? ack1 : ack0) && lat < 10);
        rd = dado_lido;
        er = erro;
        drive(r, 1'b0, esc, a, d);
        step();
    endtask

    function automatic logic [7:0] pick_addr();
        case ($urandom_range(0, 7))
            0:       return 8'd29;
            1:       return 8'd30;
            2:       return 8'd255;
            3:       return 8'($urandom_range(30, 255));
            default: return 8'($urandom_range(0, 29));
        endcase
    endfunction

    bit         act [2];
    bit         res [2];
    logic [7:0] ra [2];
    logic [7:0] rdat [2];

    initial begin
        logic [7:0] rd;
        logic       er;
        int         lat;
        int         g[$];
        int         t[$];
        int         k;
        int         nstrb;

        // Reset held with a pending request.
        reset = 1'b0;
        drive(0, 1'b1, 1'b0, 8'd5, 8'h00);
        step();
        step();

        // Contention right after reset: reads of 3 and 7, first grant to requester 0.
        reset = 1'b1;
        drive(0, 1'b1, 1'b0, 8'd3, 8'h00);
        drive(1, 1'b1, 1'b0, 8'd7, 8'h00);
        k = 0;
        while (g.size() < 5 && k < 40) begin
            step();
            k++;
            if (ack0) begin g.push_back(0); t.push_back(k); end
            if (ack1) begin g.push_back(1); t.push_back(k); end
            if (g.size() == 4 && req1) drive(1, 1'b0, 1'b0, 8'd7, 8'h00);
        end
        drive(0, 1'b0, 1'b0, 8'd3, 8'h00);
        step();
        chk("cont_count", g.size(), 5);
        for (int i = 0; i < g.size(); i++) chk("cont_order", g[i], i % 2);
        for (int i = 1; i < t.size(); i++) chk("cont_gap", t[i] - t[i-1], 3);

        // Write then read address 5.
        run_txn(0, 1'b1, 8'd5, 8'hA5, rd, er, lat);
        chk("w5_lat", lat, 2);
        chk("w5_erro", er, 0);
        run_txn(0, 1'b0, 8'd5, 8'h00, rd, er, lat);
        chk("r5_lat", lat, 2);
        chk("r5_data", rd, 8'hA5);

        // Address boundary.
        run_txn(0, 1'b1, 8'd29, 8'h3C, rd, er, lat);
        chk("w29_erro", er, 0);
        run_txn(1, 1'b1, 8'd30, 8'h11, rd, er, lat);
        chk("w30_erro", er, 1);
        run_txn(0, 1'b1, 8'd255, 8'h22, rd, er, lat);
        chk("w255_erro", er, 1);
        run_txn(1, 1'b0, 8'd29, 8'h00, rd, er, lat);
        chk("r29_data", rd, 8'h3C);
        chk("r29_erro", er, 0);
        run_txn(0, 1'b0, 8'd30, 8'h00, rd, er, lat);
        chk("r30_data", rd, 8'h00);
        chk("r30_erro", er, 1);

        // No duplicate access after req drops on the ack edge.
        nstrb = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            nstrb += int'(LerMemo) + int'(EscrMemo);
        end
        chk("no_dup", nstrb, 0);

        // Reset during the read access cycle aborts it.
        drive(0, 1'b1, 1'b0, 8'd9, 8'h00);
        step();
        chk("mid_ler", LerMemo, 1);
        reset = 1'b0;
        drive(0, 1'b0, 1'b0, 8'd9, 8'h00);
        step();
        reset = 1'b1;
        step();
        run_txn(1, 1'b1, 8'd9, 8'h5A, rd, er, lat);
        chk("post_rst_lat", lat, 2);
        run_txn(1, 1'b0, 8'd9, 8'h00, rd, er, lat);
        chk("post_rst_data", rd, 8'h5A);

        // Random traffic from both requesters obeying the handshake.
        for (int c = 0; c < 1500; c++) begin
            for (int r = 0; r < 2; r++) begin
                if (act[r] && e_ack[r]) act[r] = 1'b0;
                if (!act[r] && $urandom_range(0, 2) != 0) begin
                    act[r]  = 1'b1;
                    res[r]  = 1'($urandom_range(0, 1));
                    ra[r]   = pick_addr();
                    rdat[r] = 8'($urandom);
                end
                drive(r, act[r], res[r], ra[r], rdat[r]);
            end
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/arbitro_dados.md
Name: arbitro_dados

Overview:
- Two-port arbiter/sequencer sharing the single-port data memory (`dados`) between requester 0 (processor datapath) and requester 1 (I/O/DMA-style port).
- Each requester issues one read or one write per request/ack handshake.
- Block drives the memory's address, write data, LerMemo and EscrMemo, and returns read data.
- Selection is round-robin; out-of-range addresses are rejected without touching memory.

Parameters:
- LARGURA_DADO, 8, data width.
- LARGURA_END, 8, address width.
- PROFUNDIDADE, 30, number of valid memory words; valid addresses are 0..PROFUNDIDADE-1.

Ports:
- clk  in  1  single clock, all state on posedge.
- reset  in  1  synchronous, active-low; sampled on posedge clk.
- req0 / req1  in  1  request from requester 0 / 1.
- esc0 / esc1  in  1  1 = write, 0 = read; held stable while req is high.
- end0 / end1  in  LARGURA_END  request address; held stable while req is high.
- dado0 / dado1  in  LARGURA_DADO  write data; held stable while req is high.
- ack0 / ack1  out  1  one-cycle completion pulse to requester 0 / 1.
- dado_lido  out  LARGURA_DADO  read result; valid while ack0 or ack1 is high.
- erro  out  1  out-of-range address flag; valid while ack0 or ack1 is high.
- label  out  LARGURA_END  memory address.
- dadoEscrito  out  LARGURA_DADO  memory write data.
- LerMemo  out  1  memory read strobe.
- EscrMemo  out  1  memory write strobe.
- escrever  in  LARGURA_DADO  memory read data; the memory updates it on negedge clk while LerMemo=1.

Behaviour:
- Reset (reset=0 at posedge):
  - estado=OCIOSO; ack0=ack1=0; erro=0; dado_lido=0; LerMemo=EscrMemo=0; label=0; dadoEscrito=0; ultimo=1.
  - Reset overrides any operation in progress: no ack is issued for an aborted request, and strobes are low the cycle after.
- FSM states: OCIOSO, ESCRITA, LEITURA, RESPOSTA. All outputs are registered or decoded from the registered state only; no combinational path from req to the strobes.
- OCIOSO:
  - Sample req0/req1.
  - If only one is high, select it. If both are high, select the requester that is not `ultimo`.
  - Latch the selected requester's address, data and esc into internal registers; record `sel`; set ultimo=sel.
  - Go to ESCRITA if esc=1, else LEITURA. With no request, stay in OCIOSO.
- ESCRITA (1 cycle):
  - label=address, dadoEscrito=data.
  - EscrMemo=1 only if address < PROFUNDIDADE; the memory writes at the posedge ending this cycle.
  - Go to RESPOSTA.
- LEITURA (1 cycle):
  - label=address; LerMemo=1 only if address < PROFUNDIDADE.
  - The memory updates escrever at mid-cycle negedge.
  - At the posedge ending this cycle, capture escrever into dado_lido (or 0 if out of range). Go to RESPOSTA.
- RESPOSTA (1 cycle):
  - ack[sel]=1, other ack=0.
  - erro=1 iff the latched address >= PROFUNDIDADE.
  - dado_lido holds the captured value for reads and 0 for writes.
  - Go to OCIOSO.
- Latency: req sampled high at edge N means the strobe cycle is N+1 and ack is high in cycle N+2. Throughput is one access per 3 cycles.
- Handshake rules:
  - The requester keeps req, esc, address and data stable until it samples ack=1.
  - On that same edge it either drops req or presents a new request.
  - req is never sampled during ESCRITA, LEITURA or RESPOSTA.
  - Deasserting req before ack is illegal; the latched request still completes.
- Fairness: under continuous requests from both requesters, grants strictly alternate 0,1,0,1…; a lone requester is served back-to-back.
- Strobes: EscrMemo and LerMemo are never high in the same cycle and are never high outside ESCRITA/LEITURA.
- Address boundary: address PROFUNDIDADE-1 is valid. Addresses PROFUNDIDADE..2^LARGURA_END-1 produce erro=1, no strobe and no memory change.

Test Plan:
- Reset: reset=0 for 2 cycles with req0=1 → all outputs 0. After reset=1, the first grant goes to requester 0 (ultimo=1).
- Single write then read, requester 0:
  - req0, esc0=1, end0=5, dado0=8'hA5 → EscrMemo=1 with label=5 in cycle N+1; ack0 in N+2 with erro=0.
  - Then read end0=5 → LerMemo=1 in the strobe cycle; ack0 with dado_lido=8'hA5.
- Contention: req0 and req1 held high continuously, both reads, to addresses 3 and 7 → ack sequence ack0, ack1, ack0, ack1, each 3 cycles apart; label alternates 3, 7.
- Boundary: write to 29 → accepted, erro=0. Write to 30 and to 255 → no EscrMemo, ack with erro=1. A following read of 29 returns the written value.
- Reset mid-operation: assert reset=0 in the LEITURA cycle → no ack; strobes are 0 on the next cycle. After release, a new req1 is served normally.
- Hold-after-ack: requester drops req on the ack edge → the FSM returns to OCIOSO and issues no duplicate access.
